// File: rtl/paddle_position_ctrl.sv
// ============================================================================
// paddle_position_ctrl : keypad strobes -> two clamped Pong paddle positions
// Revision 1.0
// ============================================================================
`default_nettype none

module paddle_position_ctrl #(
  parameter int Y_W      = 4,
  parameter int Y_MAX    = 12,
  parameter int Y_INIT   = 6,
  parameter int STEP     = 1,
  parameter int HOLD_CYC = 4,
  parameter int REPEAT   = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           center,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  output logic [Y_W-1:0] pad1_y,
  output logic [Y_W-1:0] pad2_y,
  output logic           pad1_top,
  output logic           pad1_bot,
  output logic           pad2_top,
  output logic           pad2_bot
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int RC_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [HC_W-1:0] C_HOLD     = HC_W'(HOLD_CYC);
  localparam logic [RC_W-1:0] C_REP_LAST = RC_W'(REPEAT - 1);
  localparam logic [Y_W:0]    C_STEP_X   = (Y_W + 1)'(STEP);
  localparam logic [Y_W:0]    C_YMAX_X   = (Y_W + 1)'(Y_MAX);
  localparam logic [Y_W-1:0]  C_YMAX     = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]  C_YINIT    = Y_W'(Y_INIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2
  } state_t;

  logic [3:0]     raw;
  logic [3:0]     held;
  logic [Y_W-1:0] y_o   [2];
  logic           top_o [2];
  logic           bot_o [2];

  assign raw = {down2, up2, down1, up1};

  // Scanner strobes last one clock per four-row scan; stretch them into levels.
  for (genvar i = 0; i < 4; i++) begin : g_hold
    logic [HC_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (raw[i]) begin
        cnt <= C_HOLD;
      end else if (cnt != '0) begin
        cnt <= cnt - HC_W'(1);
      end
    end

    assign held[i] = (cnt != '0);
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    state_t          state, state_nx;
    logic [RC_W-1:0] rep, rep_nx;
    logic [Y_W-1:0]  y, y_nx;
    logic [Y_W:0]    y_x;
    logic [Y_W-1:0]  y_up, y_dn;
    logic            top, bot;
    logic            up_h, dn_h;

    assign up_h = held[2*p];
    assign dn_h = held[2*p+1];

    // Extra headroom bit keeps the clamp compare free of wrap-around.
    assign y_x  = {1'b0, y};
    assign y_up = (y_x < C_STEP_X) ? '0 : Y_W'(y_x - C_STEP_X);
    assign y_dn = (y_x > (C_YMAX_X - C_STEP_X)) ? C_YMAX : Y_W'(y_x + C_STEP_X);

    always_comb begin
      state_nx = state;
      rep_nx   = rep;
      y_nx     = y;
      if (center) begin
        y_nx     = C_YINIT;
        state_nx = IDLE;
        rep_nx   = '0;
      end else if (!en) begin
        state_nx = IDLE;
        rep_nx   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (up_h && !dn_h) begin
              y_nx     = y_up;
              state_nx = MOVE_UP;
              rep_nx   = '0;
            end else if (dn_h && !up_h) begin
              y_nx     = y_dn;
              state_nx = MOVE_DN;
              rep_nx   = '0;
            end
          end
          MOVE_UP: begin
            if (!up_h || dn_h) begin
              state_nx = IDLE;
              rep_nx   = '0;
            end else if (rep == C_REP_LAST) begin
              y_nx   = y_up;
              rep_nx = '0;
            end else begin
              rep_nx = rep + RC_W'(1);
            end
          end
          MOVE_DN: begin
            if (!dn_h || up_h) begin
              state_nx = IDLE;
              rep_nx   = '0;
            end else if (rep == C_REP_LAST) begin
              y_nx   = y_dn;
              rep_nx = '0;
            end else begin
              rep_nx = rep + RC_W'(1);
            end
          end
          default: begin
            state_nx = IDLE;
            rep_nx   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        rep   <= '0;
        y     <= C_YINIT;
        top   <= (Y_INIT == 0);
        bot   <= (Y_INIT == Y_MAX);
      end else begin
        state <= state_nx;
        rep   <= rep_nx;
        y     <= y_nx;
        top   <= (y_nx == '0);
        bot   <= (y_nx == C_YMAX);
      end
    end

    assign y_o[p]   = y;
    assign top_o[p] = top;
    assign bot_o[p] = bot;
  end

  assign pad1_y   = y_o[0];
  assign pad2_y   = y_o[1];
  assign pad1_top = top_o[0];
  assign pad1_bot = bot_o[0];
  assign pad2_top = top_o[1];
  assign pad2_bot = bot_o[1];

endmodule

`default_nettype wire
